float_dot_accum: RTL
====================

FLOAT_DOT_ACCUM -- requirements
Module: float_dot_accum

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the element counter.
REQ-002 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  begins a new dot product; accepted only in IDLE.
REQ-005 SHALL have port bias  input  32  IEEE-754 single-precision bias; sampled when start is accepted.
REQ-006 SHALL have port relu_en  input  1  selects ReLU on the result; sampled when start is accepted.
REQ-007 SHALL have port in_valid  input  1  the a/w pair is valid.
REQ-008 SHALL have port in_ready  output  1  the block accepts a pair this cycle.
REQ-009 SHALL have port in_a  input  32  activation operand, float32.
REQ-010 SHALL have port in_w  input  32  weight operand, float32.
REQ-011 SHALL have port in_last  input  1  marks the final pair of the vector.
REQ-012 SHALL have port out_valid  output  1  the result is valid.
REQ-013 SHALL have port out_ready  input  1  the consumer accepts the result.
REQ-014 SHALL have port out_data  output  32  result, float32.
REQ-015 SHALL have port out_count  output  CNT_W  number of pairs accepted.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, ACCUM, DRAIN, BIAS and OUT.
REQ-018 SHALL, in IDLE with start=1, latch bias and relu_en, clear the accumulator to 32'h00000000, clear the counter, and go to ACCUM.
REQ-019 SHALL drive in_ready=1 only in ACCUM; a pair transfers when in_valid and in_ready are both 1.
REQ-020 SHALL, on transfer, register prod = Float_Mul(in_a, in_w) and assert prod_valid on the next cycle (one-cycle multiply stage).
REQ-021 SHALL, each cycle prod_valid=1, update acc <= Float_Add(acc, prod) (one-cycle accumulate stage); idle cycles leave acc unchanged.
REQ-022 SHALL, on transfer, increment the counter, saturating at all-ones.
REQ-023 SHALL, on transfer with in_last=1, go to DRAIN and drop in_ready on the next cycle.
REQ-024 SHALL leave DRAIN for BIAS only when prod_valid=0, i.e. after the last product has been added.
REQ-025 SHALL, in BIAS, perform acc <= Float_Add(acc, bias_q) for exactly one cycle, then go to OUT.
REQ-026 SHALL, in OUT, hold out_valid=1 and out_data = (relu_en_q && acc[31]) ? 32'h0 : acc, both stable until out_ready=1.
REQ-027 SHALL return to IDLE on the out_valid && out_ready cycle; out_count holds its value until the next accepted start.
REQ-028 SHALL ignore start outside IDLE, including start asserted in the same cycle as the OUT handshake.
REQ-029 SHALL ignore in_valid outside ACCUM; no pair is consumed and the counter is unchanged.
REQ-030 SHALL have a minimum latency of 4 cycles from the last transfer to out_valid: product, accumulate, DRAIN exit, bias.

Reset
REQ-031 SHALL, on Reset_n=0 and independent of Clk, force state IDLE and clear acc, prod, prod_valid, the latched bias/relu_en and the counter.
REQ-032 SHALL, during reset, drive in_ready=0, out_valid=0, out_data=0, out_count=0 and busy=0.
REQ-033 SHALL, after reset asserted mid-operation, discard all partial sums; the next start begins a clean vector.

Structure
REQ-034 SHALL place typedef float32_t (32-bit logic), constants FP_ZERO=32'h00000000 and FP_ONE=32'h3F800000, and the state enum in shared package float_pkg.
REQ-035 SHALL instantiate the team's existing combinational Float_Mul and Float_Add (one Float_Add, with its operand muxed between prod and bias_q); no new sub-module.

Verification
REQ-036 SHALL cover dot product: bias=0, pairs (3F800000,40000000), (40400000,3F000000, last) -> out_data=40600000 (3.5), out_count=2.
REQ-037 SHALL cover ReLU: pair (3F800000,BF800000, last), bias=0; relu_en=1 -> out_data=00000000; relu_en=0 -> out_data=BF800000.
REQ-038 SHALL cover bias and bubbles: pairs (40000000,40000000) and (3F800000,3F800000, last) with 3 idle cycles between them, bias=3F800000 -> out_data=40C00000 (6.0).
REQ-039 SHALL cover output backpressure: out_ready=0 for 5 cycles in OUT -> out_valid=1 and out_data stable, in_ready=0; acceptance -> IDLE, busy=0.
REQ-040 SHALL cover reset mid-ACCUM: Reset_n pulsed low after 1 pair -> all outputs 0 at once; a fresh vector (3F800000,3F800000, last) -> out_data=3F800000, out_count=1.
REQ-041 SHALL cover start during OUT (with and without out_ready) -> start ignored, result unchanged, and no new run begins.

Source files
------------

// File: rtl/float_pkg.sv
// Shared float32 types, constants and the dot-product FSM state encoding.
package float_pkg;

  typedef logic [31:0] float32_t;

  localparam float32_t FP_ZERO = 32'h0000_0000;
  localparam float32_t FP_ONE  = 32'h3F80_0000;
  localparam float32_t FP_QNAN = 32'h7FC0_0000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ACCUM = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_BIAS  = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ACCUM = ST_ACCUM,
    S_DRAIN = ST_DRAIN,
    S_BIAS  = ST_BIAS,
    S_OUT   = ST_OUT
  } state_e;

endpackage

// File: rtl/float_dot_accum_if.sv
// Operand-in / result-out stream bundle for float_dot_accum.
interface float_dot_accum_if;
  import float_pkg::*;

  logic     in_valid;
  logic     in_ready;
  float32_t in_a;
  float32_t in_w;
  logic     in_last;
  logic     out_valid;
  logic     out_ready;
  float32_t out_data;

  modport master (
    output in_valid, in_a, in_w, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_w, in_last, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/Float_Add.sv
// Combinational float32 add: round-to-nearest-even, denormals flushed to zero.
module Float_Add
  import float_pkg::*;
(
  input  float32_t a,
  input  float32_t b,
  output float32_t y
);

  function automatic logic [4:0] clz27(input logic [26:0] v);
    logic [4:0] c;
    logic       found;
    c     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (v[i]) found = 1'b1;
      else if (!found) c = c + 5'd1;
    end
    return c;
  endfunction

  float32_t          x, z;
  logic              a_inf, b_inf, a_nan, b_nan;
  logic [7:0]        d8;
  logic [4:0]        dsh, lz;
  logic [26:0]       mx, my, n;
  logic [53:0]       sh;
  logic [27:0]       sum;
  logic              rnd;
  logic [23:0]       r;
  logic signed [9:0] e;

  always_comb begin
    y     = FP_ZERO;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    // x is the larger magnitude; it sets the result sign and exponent
    x     = (b[30:0] > a[30:0]) ? b : a;
    z     = (b[30:0] > a[30:0]) ? a : b;
    d8    = x[30:23] - z[30:23];
    dsh   = (d8 > 8'd27) ? 5'd27 : d8[4:0];
    mx    = {1'b1, x[22:0], 3'b000};
    sh    = {1'b1, z[22:0], 3'b000, 27'd0} >> dsh;
    my    = {sh[53:28], sh[27] | (|sh[26:0])};
    e     = $signed({2'b00, x[30:23]});
    sum   = '0;
    n     = '0;
    lz    = '0;
    rnd   = 1'b0;
    r     = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      y = FP_QNAN;
    end else if (a_inf || b_inf) begin
      y = a_inf ? a : b;
    end else if (x[30:23] == 8'h00) begin
      y = FP_ZERO;
    end else if (z[30:23] == 8'h00) begin
      y = x;
    end else begin
      if (x[31] == z[31]) begin
        sum = {1'b0, mx} + {1'b0, my};
        if (sum[27]) begin
          n = {sum[27:2], sum[1] | sum[0]};
          e = e + 10'sd1;
        end else begin
          n = sum[26:0];
        end
      end else begin
        n  = mx - my;
        lz = clz27(n);
        n  = n << lz;
        e  = e - $signed({5'd0, lz});
      end
      rnd = n[2] & (n[3] | n[1] | n[0]);
      r   = {1'b0, n[25:3]} + {23'd0, rnd};
      if (r[23]) e = e + 10'sd1;
      if (n == '0)          y = FP_ZERO;
      else if (e >= 10'sd255) y = {x[31], 8'hFF, 23'd0};
      else if (e <= 10'sd0)  y = FP_ZERO;
      else                  y = {x[31], e[7:0], r[22:0]};
    end
  end

endmodule

// File: rtl/Float_Mul.sv
// Combinational float32 multiply: round-to-nearest-even, denormals flushed to zero.
module Float_Mul
  import float_pkg::*;
(
  input  float32_t a,
  input  float32_t b,
  output float32_t y
);

  logic              s;
  logic [47:0]       p;
  logic [22:0]       m;
  logic              g, st, rnd;
  logic [23:0]       r;
  logic signed [9:0] e;

  always_comb begin
    y   = FP_ZERO;
    s   = a[31] ^ b[31];
    p   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e   = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    m   = '0;
    g   = 1'b0;
    st  = 1'b0;
    rnd = 1'b0;
    r   = '0;
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0)) begin
      y = FP_QNAN;
    end else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      // inf * 0 is invalid; any other inf product keeps the XOR sign
      if (a[30:23] == 8'h00 || b[30:23] == 8'h00) y = FP_QNAN;
      else                                        y = {s, 8'hFF, 23'd0};
    end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
      y = {s, 31'd0};
    end else begin
      if (p[47]) begin
        m  = p[46:24];
        g  = p[23];
        st = |p[22:0];
        e  = e + 10'sd1;
      end else begin
        m  = p[45:23];
        g  = p[22];
        st = |p[21:0];
      end
      rnd = g & (st | m[0]);
      r   = {1'b0, m} + {23'd0, rnd};
      if (r[23]) e = e + 10'sd1;
      if (e >= 10'sd255)   y = {s, 8'hFF, 23'd0};
      else if (e <= 10'sd0) y = {s, 31'd0};
      else                 y = {s, e[7:0], r[22:0]};
    end
  end

endmodule

// File: rtl/float_dot_accum.sv
// Streaming float32 dot product: multiply stage, accumulate stage, bias add,
// optional ReLU, held result with ready/valid handshake.
module float_dot_accum
  import float_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  float32_t         bias,
  input  logic             relu_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  float32_t         in_a,
  input  float32_t         in_w,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output float32_t         out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  state_e           state_q, state_d;
  float32_t         acc_q, acc_d;
  float32_t         prod_q, bias_q;
  logic             prod_valid_q, relu_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  float32_t mul_y, add_b, add_y;
  logic     xfer, start_acc;

  Float_Mul u_mul (.a(in_a),  .b(in_w),  .y(mul_y));
  Float_Add u_add (.a(acc_q), .b(add_b), .y(add_y));

  always_comb begin
    in_ready  = (state_q == S_ACCUM);
    out_valid = (state_q == S_OUT);
    busy      = (state_q != S_IDLE);
    out_count = cnt_q;
    out_data  = FP_ZERO;
    if (state_q == S_OUT && !(relu_q && acc_q[31])) out_data = acc_q;

    xfer      = in_valid && in_ready;
    start_acc = (state_q == S_IDLE) && start;
    // Products and the bias never collide: BIAS is entered only once prod_valid is low
    add_b     = (state_q == S_BIAS) ? bias_q : prod_q;

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (start_acc) begin
      acc_d = FP_ZERO;
      cnt_d = '0;
    end else if (prod_valid_q || state_q == S_BIAS) begin
      acc_d = add_y;
    end
    if (xfer && !(&cnt_q)) cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      S_IDLE:  if (start)                state_d = S_ACCUM;
      S_ACCUM: if (xfer && in_last)      state_d = S_DRAIN;
      S_DRAIN: if (!prod_valid_q)        state_d = S_BIAS;
      S_BIAS:                            state_d = S_OUT;
      S_OUT:   if (out_ready)            state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      acc_q        <= FP_ZERO;
      prod_q       <= FP_ZERO;
      prod_valid_q <= 1'b0;
      bias_q       <= FP_ZERO;
      relu_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      prod_valid_q <= xfer;
      if (xfer) prod_q <= mul_y;
      if (start_acc) begin
        bias_q <= bias;
        relu_q <= relu_en;
      end
    end
  end

endmodule
